// File: rtl/btn_pkg.sv
// Shared constants for the button debouncer: FSM state encodings and the
// default debounce / auto-repeat tick counts.
package btn_pkg;

    // Per-button FSM state encodings
    localparam logic [1:0] ST_RELEASED     = 2'd0;
    localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
    localparam logic [1:0] ST_PRESSED      = 2'd2;
    localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

    // Default tick counts
    localparam int DBTICKS_DEF   = 4;
    localparam int HOLDTICKS_DEF = 32;
    localparam int RPTTICKS_DEF  = 8;

    // The debounced level is high while the accepted state is "down"
    function automatic logic is_down(input logic [1:0] st);
        return (st == ST_PRESSED) || (st == ST_RELEASE_WAIT);
    endfunction

endpackage

// File: rtl/btn_chan.sv
// One debounced button channel: 2-flop synchronizer, debounce FSM with its
// tick counter, and registered press/release event pulses.
// Optional auto-repeat on long holds is compiled in when
// BTN_DEBOUNCER_REPEAT_EN is defined.
module btn_chan
    import btn_pkg::*;
#(
    parameter int DBTICKS   = DBTICKS_DEF
`ifdef BTN_DEBOUNCER_REPEAT_EN
    ,
    parameter int HOLDTICKS = HOLDTICKS_DEF,
    parameter int RPTTICKS  = RPTTICKS_DEF
`endif
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic tick,
    input  logic raw,
    output logic btn,
    output logic pressed,
    output logic released
);

    localparam logic [3:0] DB_LAST = 4'(DBTICKS - 1);

    logic       meta;
    logic       sync;
    logic [1:0] state;
    logic [1:0] state_nx;
    logic [3:0] count;
    logic [3:0] count_nx;
    logic       down;
    logic       down_nx;
    logic       rpt_fire;

    // Two-flop synchronizer for the raw asynchronous button level
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            meta <= 1'b0;
            sync <= 1'b0;
        end else begin
            meta <= raw;
            sync <= meta;
        end
    end

    // Next-state logic: a reverted level aborts a wait before any tick is counted
    always_comb begin
        state_nx = state;
        count_nx = count;
        case (state)
            ST_RELEASED: begin
                if (sync) begin
                    state_nx = ST_PRESS_WAIT;
                    count_nx = '0;
                end
            end
            ST_PRESS_WAIT: begin
                if (!sync) begin
                    state_nx = ST_RELEASED;
                end else if (tick) begin
                    if (count == DB_LAST) state_nx = ST_PRESSED;
                    else                  count_nx = count + 4'd1;
                end
            end
            ST_PRESSED: begin
                if (!sync) begin
                    state_nx = ST_RELEASE_WAIT;
                    count_nx = '0;
                end
            end
            ST_RELEASE_WAIT: begin
                if (sync) begin
                    state_nx = ST_PRESSED;
                end else if (tick) begin
                    if (count == DB_LAST) state_nx = ST_RELEASED;
                    else                  count_nx = count + 4'd1;
                end
            end
            default: state_nx = ST_RELEASED;
        endcase
    end

    // FSM state and debounce tick counter
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state <= ST_RELEASED;
            count <= '0;
        end else begin
            state <= state_nx;
            count <= count_nx;
        end
    end

`ifdef BTN_DEBOUNCER_REPEAT_EN
    // After the first repeat the counter is pulled back so it re-reaches
    // HOLDTICKS every RPTTICKS ticks without ever wrapping.
    localparam logic [7:0] HOLD_LAST = 8'(HOLDTICKS - 1);
    localparam logic [7:0] RELOAD    = 8'(HOLDTICKS - RPTTICKS);

    logic [7:0] hold;
    logic [7:0] hold_nx;

    // Hold counter: cleared on a fresh press, frozen outside PRESSED
    always_comb begin
        hold_nx  = hold;
        rpt_fire = 1'b0;
        if (state == ST_PRESS_WAIT && state_nx == ST_PRESSED) begin
            hold_nx = '0;
        end else if (state == ST_PRESSED && state_nx == ST_PRESSED && tick) begin
            if (hold == HOLD_LAST) begin
                rpt_fire = 1'b1;
                hold_nx  = RELOAD;
            end else begin
                hold_nx = hold + 8'd1;
            end
        end
    end

    // Hold counter register
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) hold <= '0;
        else            hold <= hold_nx;
    end
`else
    assign rpt_fire = 1'b0;
`endif

    assign down    = is_down(state);
    assign down_nx = is_down(state_nx);
    assign btn     = down;

    // Event pulses registered from the upcoming level so they line up with btn
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            pressed  <= 1'b0;
            released <= 1'b0;
        end else begin
            pressed  <= (down_nx & ~down) | rpt_fire;
            released <= ~down_nx & down;
        end
    end

endmodule

// File: rtl/btn_debouncer.sv
// Multi-button debouncer top: one shared free-running prescaler producing a
// debounce tick, and NBTNS independent btn_chan channels.
// Optional macro: BTN_DEBOUNCER_REPEAT_EN enables auto-repeat on long holds
// (adds HOLDTICKS / RPTTICKS parameters).
module btn_debouncer
    import btn_pkg::*;
#(
    parameter int NBTNS     = 5,
    parameter int CTRBITS   = 20,
    parameter int DBTICKS   = DBTICKS_DEF
`ifdef BTN_DEBOUNCER_REPEAT_EN
    ,
    parameter int HOLDTICKS = HOLDTICKS_DEF,
    parameter int RPTTICKS  = RPTTICKS_DEF
`endif
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic [NBTNS-1:0] i_btn,
    output logic [NBTNS-1:0] o_btn,
    output logic [NBTNS-1:0] o_pressed,
    output logic [NBTNS-1:0] o_released
);

    logic [CTRBITS-1:0] presc;
    logic               tick;

    // Free-running prescaler shared by every channel
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) presc <= '0;
        else            presc <= presc + 1'b1;
    end

    // Tick marks the cycle in which the prescaler wraps to zero
    assign tick = &presc;

    for (genvar k = 0; k < NBTNS; k++) begin : g_chan
        btn_chan #(
            .DBTICKS   (DBTICKS)
`ifdef BTN_DEBOUNCER_REPEAT_EN
            ,
            .HOLDTICKS (HOLDTICKS),
            .RPTTICKS  (RPTTICKS)
`endif
        ) u_chan (
            .i_clk     (i_clk),
            .i_reset_n (i_reset_n),
            .tick      (tick),
            .raw       (i_btn[k]),
            .btn       (o_btn[k]),
            .pressed   (o_pressed[k]),
            .released  (o_released[k])
        );
    end

endmodule

// File: tb/tb_btn_debouncer.sv
// Directed bench for btn_debouncer with NBTNS=2, CTRBITS=4, DBTICKS=3.
// Auto-repeat scenario is built when BTN_DEBOUNCER_REPEAT_EN is defined
// (HOLDTICKS=4, RPTTICKS=2).
module tb_btn_debouncer;

    logic       i_clk = 1'b0;
    logic       i_reset_n;
    logic [1:0] i_btn;
    logic [1:0] o_btn;
    logic [1:0] o_pressed;
    logic [1:0] o_released;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 i_clk = ~i_clk;

    btn_debouncer #(
        .NBTNS     (2),
        .CTRBITS   (4),
        .DBTICKS   (3)
`ifdef BTN_DEBOUNCER_REPEAT_EN
        ,
        .HOLDTICKS (4),
        .RPTTICKS  (2)
`endif
    ) dut (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_btn      (i_btn),
        .o_btn      (o_btn),
        .o_pressed  (o_pressed),
        .o_released (o_released)
    );

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // Button held through reset: everything must read 0 while reset is low
    task automatic test_reset();
        i_reset_n = 1'b0;
        i_btn     = 2'b11;
        repeat (3) step();
        n_checks++;
        if (o_btn !== 2'b00) $display("FAIL reset_btn got=%b exp=00", o_btn);
        else n_pass++;
        n_checks++;
        if (o_pressed !== 2'b00) $display("FAIL reset_pressed got=%b exp=00", o_pressed);
        else n_pass++;
        n_checks++;
        if (o_released !== 2'b00) $display("FAIL reset_released got=%b exp=00", o_released);
        else n_pass++;
        i_btn     = 2'b00;
        i_reset_n = 1'b1;
        repeat (4) step();
    endtask

    // Clean press of button 0
    task automatic test_press();
        int         lat = -1;
        logic [1:0] pr_at_rise = 2'b00;
        bit         rel_seen = 0;
        bit         early_pr = 0;
        i_btn = 2'b01;
        for (int n = 1; n <= 60; n++) begin
            step();
            if (o_released !== 2'b00) rel_seen = 1;
            if (o_btn[0] === 1'b1) begin
                lat = n;
                pr_at_rise = o_pressed;
                break;
            end
            if (o_pressed !== 2'b00) early_pr = 1;
        end
        n_checks++;
        if (lat < 32 || lat > 51) $display("FAIL press_latency got=%0d exp=32..51", lat);
        else n_pass++;
        n_checks++;
        if (pr_at_rise !== 2'b01) $display("FAIL press_pulse_coincident got=%b exp=01", pr_at_rise);
        else n_pass++;
        step();
        n_checks++;
        if (o_pressed !== 2'b00) $display("FAIL press_pulse_width got=%b exp=00", o_pressed);
        else n_pass++;
        n_checks++;
        if (o_btn !== 2'b01) $display("FAIL press_level got=%b exp=01", o_btn);
        else n_pass++;
        n_checks++;
        if (rel_seen || early_pr) $display("FAIL press_spurious got=rel%0d/early%0d exp=0/0", rel_seen, early_pr);
        else n_pass++;
    endtask

    // Clean release of button 0
    task automatic test_release();
        int         lat = -1;
        logic [1:0] rl_at_fall = 2'b00;
        i_btn = 2'b00;
        for (int n = 1; n <= 60; n++) begin
            step();
            if (o_btn[0] === 1'b0) begin
                lat = n;
                rl_at_fall = o_released;
                break;
            end
        end
        n_checks++;
        if (lat < 32 || lat > 51) $display("FAIL release_latency got=%0d exp=32..51", lat);
        else n_pass++;
        n_checks++;
        if (rl_at_fall !== 2'b01) $display("FAIL release_pulse got=%b exp=01", rl_at_fall);
        else n_pass++;
        step();
        n_checks++;
        if (o_released !== 2'b00) $display("FAIL release_pulse_width got=%b exp=00", o_released);
        else n_pass++;
    endtask

    // 20-clock blip must be rejected
    task automatic test_glitch();
        bit btn_seen = 0;
        bit pr_seen  = 0;
        i_btn = 2'b01;
        for (int n = 0; n < 80; n++) begin
            if (n == 20) i_btn = 2'b00;
            step();
            if (o_btn !== 2'b00) btn_seen = 1;
            if (o_pressed !== 2'b00) pr_seen = 1;
        end
        n_checks++;
        if (btn_seen) $display("FAIL glitch_btn got=1 exp=0");
        else n_pass++;
        n_checks++;
        if (pr_seen) $display("FAIL glitch_pressed got=1 exp=0");
        else n_pass++;
    endtask

    // Short release inside a press must not drop the level
    task automatic test_bounce_release();
        bit up_ok    = 0;
        bit dropped  = 0;
        bit rel_seen = 0;
        bit down_ok  = 0;
        i_btn = 2'b01;
        for (int n = 0; n < 60; n++) begin
            step();
            if (o_btn[0] === 1'b1) begin
                up_ok = 1;
                break;
            end
        end
        n_checks++;
        if (!up_ok) $display("FAIL bounce_press_timeout got=0 exp=1");
        else n_pass++;
        i_btn = 2'b00;
        for (int n = 0; n < 80; n++) begin
            if (n == 10) i_btn = 2'b01;
            step();
            if (o_btn[0] !== 1'b1) dropped = 1;
            if (o_released !== 2'b00) rel_seen = 1;
        end
        n_checks++;
        if (dropped) $display("FAIL bounce_level got=0 exp=1");
        else n_pass++;
        n_checks++;
        if (rel_seen) $display("FAIL bounce_released got=1 exp=0");
        else n_pass++;
        i_btn = 2'b00;
        for (int n = 0; n < 60; n++) begin
            step();
            if (o_btn[0] === 1'b0) begin
                down_ok = 1;
                break;
            end
        end
        n_checks++;
        if (!down_ok) $display("FAIL bounce_release_timeout got=0 exp=1");
        else n_pass++;
        repeat (2) step();
    endtask

    // Both buttons in the same cycle
    task automatic test_simultaneous();
        logic [1:0] pr = 2'b00;
        logic [1:0] lv = 2'b00;
        logic [1:0] rl = 2'b00;
        i_btn = 2'b11;
        for (int n = 0; n < 60; n++) begin
            step();
            if (o_pressed !== 2'b00) begin
                pr = o_pressed;
                lv = o_btn;
                break;
            end
        end
        n_checks++;
        if (pr !== 2'b11) $display("FAIL simul_pressed got=%b exp=11", pr);
        else n_pass++;
        n_checks++;
        if (lv !== 2'b11) $display("FAIL simul_level got=%b exp=11", lv);
        else n_pass++;
        i_btn = 2'b00;
        for (int n = 0; n < 60; n++) begin
            step();
            if (o_released !== 2'b00) begin
                rl = o_released;
                break;
            end
        end
        n_checks++;
        if (rl !== 2'b11) $display("FAIL simul_released got=%b exp=11", rl);
        else n_pass++;
        repeat (2) step();
    endtask

    // Reset while pressed and held: press must be re-debounced afterwards
    task automatic test_reset_mid();
        bit         up_ok = 0;
        int         lat = -1;
        logic       lv = 1'b0;
        i_btn = 2'b01;
        for (int n = 0; n < 60; n++) begin
            step();
            if (o_btn[0] === 1'b1) begin
                up_ok = 1;
                break;
            end
        end
        n_checks++;
        if (!up_ok) $display("FAIL rstmid_press_timeout got=0 exp=1");
        else n_pass++;
        repeat (5) step();
        i_reset_n = 1'b0;
        step();
        n_checks++;
        if (o_btn !== 2'b00) $display("FAIL rstmid_btn got=%b exp=00", o_btn);
        else n_pass++;
        n_checks++;
        if (o_pressed !== 2'b00) $display("FAIL rstmid_pressed got=%b exp=00", o_pressed);
        else n_pass++;
        n_checks++;
        if (o_released !== 2'b00) $display("FAIL rstmid_released got=%b exp=00", o_released);
        else n_pass++;
        i_reset_n = 1'b1;
        for (int n = 1; n <= 60; n++) begin
            step();
            if (o_pressed[0] === 1'b1) begin
                lat = n;
                lv  = o_btn[0];
                break;
            end
        end
        n_checks++;
        if (lat < 32 || lat > 51) $display("FAIL rstmid_latency got=%0d exp=32..51", lat);
        else n_pass++;
        n_checks++;
        if (lv !== 1'b1) $display("FAIL rstmid_level got=%b exp=1", lv);
        else n_pass++;
    endtask

`ifdef BTN_DEBOUNCER_REPEAT_EN
    // Held button repeats: 64 clocks to the first repeat, then every 32
    task automatic test_repeat();
        int exp_gap[3] = '{64, 32, 32};
        for (int r = 0; r < 3; r++) begin
            int gap = -1;
            for (int n = 1; n <= 100; n++) begin
                step();
                if (o_pressed[0] === 1'b1) begin
                    gap = n;
                    break;
                end
            end
            n_checks++;
            if (gap !== exp_gap[r]) $display("FAIL repeat_gap%0d got=%0d exp=%0d", r, gap, exp_gap[r]);
            else n_pass++;
        end
        n_checks++;
        if (o_btn[0] !== 1'b1) $display("FAIL repeat_level got=%b exp=1", o_btn[0]);
        else n_pass++;
    endtask
`else
    // Held button produces exactly one press pulse
    task automatic test_no_repeat();
        bit pr_seen = 0;
        bit dropped = 0;
        for (int n = 0; n < 200; n++) begin
            step();
            if (o_pressed !== 2'b00) pr_seen = 1;
            if (o_btn[0] !== 1'b1) dropped = 1;
        end
        n_checks++;
        if (pr_seen) $display("FAIL norepeat_pressed got=1 exp=0");
        else n_pass++;
        n_checks++;
        if (dropped) $display("FAIL norepeat_level got=0 exp=1");
        else n_pass++;
    endtask
`endif

    initial begin
        i_reset_n = 1'b0;
        i_btn     = 2'b00;
        test_reset();
        test_press();
        test_release();
        test_glitch();
        test_bounce_release();
        test_simultaneous();
        test_reset_mid();
`ifdef BTN_DEBOUNCER_REPEAT_EN
        test_repeat();
`else
        test_no_repeat();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/btn_debouncer.md
BTN_DEBOUNCER -- requirements
Module: btn_debouncer

Interface
REQ-001 SHALL have parameter NBTNS, default 5, number of independent button/switch inputs.
REQ-002 SHALL have parameter CTRBITS, default 20, prescaler width; one tick every 2^CTRBITS clocks.
REQ-003 SHALL have parameter DBTICKS, default 4, number of ticks an input must stay stable before a change is accepted (range 2..15).
REQ-004 SHALL have port i_clk, input, 1, sole clock.
REQ-005 SHALL have port i_reset_n, input, 1, synchronous active-low reset.
REQ-006 SHALL have port i_btn, input, NBTNS, raw asynchronous button levels, 1 = pressed.
REQ-007 SHALL have port o_btn, output, NBTNS, debounced level per button.
REQ-008 SHALL have port o_pressed, output, NBTNS, one-cycle press-event pulse per button.
REQ-009 SHALL have port o_released, output, NBTNS, one-cycle release-event pulse per button.

Function
REQ-010 SHALL pass each i_btn bit through a 2-flop synchronizer; all logic below uses the synchronized bit (sync).
REQ-011 SHALL run one free-running CTRBITS-bit prescaler shared by all buttons; tick is high for one cycle when the prescaler wraps from all-ones to zero.
REQ-012 SHALL give each button an independent FSM with states RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT and a tick counter (4 bits).
REQ-013 SHALL transition RELEASED->PRESS_WAIT with count cleared when sync=1.
REQ-014 SHALL in PRESS_WAIT return to RELEASED when sync=0 (glitch rejected, no pulse); on tick with sync=1 increment count; on the tick where count==DBTICKS-1 enter PRESSED.
REQ-015 SHALL transition PRESSED->RELEASE_WAIT with count cleared when sync=0.
REQ-016 SHALL in RELEASE_WAIT return to PRESSED when sync=1 (no pulse); on the tick where count==DBTICKS-1 with sync=0 enter RELEASED.
REQ-017 SHALL drive o_btn[k] high exactly while FSM k is in PRESSED or RELEASE_WAIT.
REQ-018 SHALL assert o_pressed[k] for exactly the first cycle o_btn[k] is high, and o_released[k] for exactly the first cycle o_btn[k] is low after being high; both registered.
REQ-019 SHALL accept a change no sooner than (DBTICKS-1)*2^CTRBITS and no later than DBTICKS*2^CTRBITS+3 clocks after the raw edge.
REQ-020 SHALL evaluate sync-level checks before tick checks when both occur in the same cycle (sync reverting on a tick cycle aborts the wait).
REQ-021 SHALL process simultaneous events on different buttons independently in the same cycle.

Reset
REQ-022 SHALL while i_reset_n=0 at a clock edge set all FSMs to RELEASED, counts, prescaler and synchronizers to 0, and o_btn, o_pressed, o_released to 0.
REQ-023 SHALL treat a button held across reset as a new press: o_pressed fires only after a full debounce following reset release.

Configuration
REQ-024 SHALL compile auto-repeat logic only when macro BTN_DEBOUNCER_REPEAT_EN is defined.
REQ-025 SHALL, with BTN_DEBOUNCER_REPEAT_EN, add parameters HOLDTICKS (default 32) and RPTTICKS (default 8) and a per-button 8-bit hold counter cleared on entering PRESSED, incremented per tick while in PRESSED; o_pressed[k] re-pulses one cycle when the counter reaches HOLDTICKS and every RPTTICKS ticks thereafter; RELEASE_WAIT freezes the counter, return to PRESSED resumes it.
REQ-026 SHALL, without the macro, produce exactly one o_pressed pulse per accepted press and no hold counters.

Structure
REQ-027 SHALL place FSM state encodings (2-bit) and default DBTICKS/HOLDTICKS/RPTTICKS constants in shared package btn_pkg.
REQ-028 SHALL implement one per-button sub-module btn_chan (synchronizer, FSM, counters, outputs), instantiated NBTNS times; the prescaler stays in the top.

Verification (CTRBITS=4, DBTICKS=3, NBTNS=2)
REQ-029 SHALL test: i_btn[0] 0->1 held -> o_btn[0] rises 32..51 clocks later, o_pressed[0] one cycle coincident; o_released stays 0.
REQ-030 SHALL test: i_btn[0] 1 for 20 clocks then 0 -> o_btn[0], o_pressed[0] never assert.
REQ-031 SHALL test: pressed button released for 10 clocks then re-pressed -> o_btn stays 1, no o_released pulse.
REQ-032 SHALL test: both buttons pressed same cycle -> o_pressed=2'b11 in one cycle.
REQ-033 SHALL test: reset asserted mid-PRESSED with button held -> all outputs 0 next cycle; after release of reset, o_pressed re-fires after 32..51 clocks.
REQ-034 SHALL test, with BTN_DEBOUNCER_REPEAT_EN, HOLDTICKS=4, RPTTICKS=2: held button -> first pulse, repeat 64 clocks later, then every 32 clocks.
